// File: rtl/datafifo.sv
`default_nettype none
// ============================================================================
// Module   : datafifo
// Purpose  : Commit-side store FIFO draining to an AXI-style write channel,
//            with a word-granular load-hazard probe.
// Revision : 1.0 - initial release
// ============================================================================
module datafifo #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_val,
    input  logic [1:0]  in_size,
    input  logic        in_valid,
    output logic        full,
    output logic        empty,
    input  logic [31:0] ld_addr,
    output logic        ld_hazard,
    output logic [31:0] awaddr,
    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wvalid,
    input  logic        wready,
    input  logic [2:0]  bresp,
    input  logic        bvalid,
    output logic        bready,
    output logic        bus_error
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [31:0]     addr_q [DEPTH];
    logic [31:0]     val_q  [DEPTH];
    logic [1:0]      size_q [DEPTH];
    logic [AW-1:0]   head_q, head_d, tail_q, tail_d;
    logic [AW:0]     count_q, count_d;
    logic            aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic            bus_error_q, bus_error_d;
    logic            w_push, w_pop, w_aw_fire, w_w_fire;
    logic [31:0]     w_head_addr, w_head_val;
    logic [1:0]      w_head_size;

    assign full      = (count_q == (AW+1)'(DEPTH));
    assign empty     = (count_q == '0);
    assign w_push    = in_valid && !full;
    assign bus_error = bus_error_q;

    assign w_head_addr = addr_q[head_q];
    assign w_head_val  = val_q[head_q];
    assign w_head_size = size_q[head_q];

    // Drain FSM; the head is held in place until its response is accepted.
    always_comb begin
        state_d     = state_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        awvalid     = 1'b0;
        wvalid      = 1'b0;
        bready      = 1'b0;
        w_pop       = 1'b0;
        w_aw_fire   = 1'b0;
        w_w_fire    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!empty) state_d = S_SEND;
            end
            S_SEND: begin
                awvalid   = !aw_done_q;
                wvalid    = !w_done_q;
                w_aw_fire = !aw_done_q && awready;
                w_w_fire  = !w_done_q && wready;
                if (w_aw_fire) aw_done_d = 1'b1;
                if (w_w_fire)  w_done_d  = 1'b1;
                if (aw_done_d && w_done_d) state_d = S_RESP;
            end
            S_RESP: begin
                bready = 1'b1;
                if (bvalid) begin
                    w_pop     = 1'b1;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        head_d      = head_q + AW'(w_pop);
        tail_d      = tail_q + AW'(w_push);
        count_d     = count_q;
        bus_error_d = w_pop && (bresp != 3'd0);
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Sub-word stores are replicated across lanes so the strobe alone selects bytes.
    always_comb begin
        awaddr = {w_head_addr[31:2], 2'b00};
        wdata  = w_head_val;
        wstrb  = 4'b0000;
        case (w_head_size)
            2'd0: begin
                wdata = {4{w_head_val[7:0]}};
                wstrb = 4'b0001 << w_head_addr[1:0];
            end
            2'd1: begin
                wdata = {2{w_head_val[15:0]}};
                wstrb = 4'b0011 << {w_head_addr[1], 1'b0};
            end
            2'd2:    wstrb = 4'b1111;
            default: wstrb = 4'b0000;
        endcase
    end

    // An entry is live when its distance from the head is below count.
    always_comb begin
        logic [AW-1:0] off;
        ld_hazard = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            off = AW'(i) - head_q;
            if (({1'b0, off} < count_q) && (addr_q[i][31:2] == ld_addr[31:2]))
                ld_hazard = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            bus_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            bus_error_q <= bus_error_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            addr_q[tail_q] <= in_addr;
            val_q[tail_q]  <= in_val;
            size_q[tail_q] <= in_size;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_datafifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_datafifo
// Purpose  : Scoreboard bench for datafifo write drain, hazard probe and reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_datafifo;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] in_addr, in_val, ld_addr;
    logic [1:0]  in_size;
    logic        in_valid, awready, wready, bvalid;
    logic [2:0]  bresp;
    logic        full, empty, ld_hazard, awvalid, wvalid, bready, bus_error;
    logic [31:0] awaddr, wdata;
    logic [3:0]  wstrb;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
        bit          chk_d;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_err = 0;
    int   n_drained = 0;

    datafifo #(.DEPTH(4)) dut (
        .clk(clk), .reset(reset),
        .in_addr(in_addr), .in_val(in_val), .in_size(in_size), .in_valid(in_valid),
        .full(full), .empty(empty),
        .ld_addr(ld_addr), .ld_hazard(ld_hazard),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .bus_error(bus_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Payload is stable for the whole SEND phase, so compare at the data handshake.
    always @(negedge clk) begin
        if (!reset && wvalid && wready) begin
            if (sb.size() == 0) begin
                check("sb_unexpected", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("awaddr", awaddr, e.a);
                check("wstrb", {28'd0, wstrb}, {28'd0, e.s});
                if (e.chk_d) check("wdata", wdata, e.d);
            end
            n_drained++;
        end
    end

    // Called at #1 after an edge; returns #1 after the push edge.
    task automatic push(input logic [31:0] a, input logic [31:0] v, input logic [1:0] sz,
                        input bit acc, input logic [31:0] ea, input logic [31:0] ed,
                        input logic [3:0] es, input bit cd);
        exp_t e;
        in_addr  = a;
        in_val   = v;
        in_size  = sz;
        in_valid = 1'b1;
        if (acc) begin
            e.a = ea; e.d = ed; e.s = es; e.chk_d = cd;
            sb.push_back(e);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic wait_empty(input string tag);
        for (int i = 0; i < 60; i++) begin
            if (empty) break;
            tick();
        end
        check(tag, {31'd0, empty}, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        reset = 1'b1; in_addr = '0; in_val = '0; in_size = '0; in_valid = 1'b0;
        ld_addr = 32'hFFFF_FFF0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        check("rst_full", {31'd0, full}, 32'd0);
        check("rst_empty", {31'd0, empty}, 32'd1);
        check("rst_hazard", {31'd0, ld_hazard}, 32'd0);
        check("rst_awvalid", {31'd0, awvalid}, 32'd0);
        check("rst_wvalid", {31'd0, wvalid}, 32'd0);
        check("rst_bready", {31'd0, bready}, 32'd0);
        check("rst_bus_error", {31'd0, bus_error}, 32'd0);

        // Word store at minimum latency
        awready = 1'b1; wready = 1'b1; bvalid = 1'b1;
        push(32'h2004, 32'hDEAD_BEEF, 2'd2, 1, 32'h2004, 32'hDEAD_BEEF, 4'b1111, 1);
        check("word_empty_e0", {31'd0, empty}, 32'd0);
        tick();
        check("word_awvalid", {31'd0, awvalid}, 32'd1);
        check("word_wvalid", {31'd0, wvalid}, 32'd1);
        tick();
        check("word_bready", {31'd0, bready}, 32'd1);
        check("word_empty_e2", {31'd0, empty}, 32'd0);
        tick();
        check("word_empty_e3", {31'd0, empty}, 32'd1);
        check("word_bready_off", {31'd0, bready}, 32'd0);

        // Byte and half stores
        push(32'h1003, 32'h0000_00AB, 2'd0, 1, 32'h1000, 32'hABAB_ABAB, 4'b1000, 1);
        push(32'h1002, 32'h0000_1234, 2'd1, 1, 32'h1000, 32'h1234_1234, 4'b1100, 1);
        wait_empty("sub_drain");

        // Fill with the address channel stalled; pointers wrap through slot 0
        awready = 1'b0;
        base = n_drained;
        for (int i = 0; i < 4; i++)
            push(32'h4000 + 32'(4 * i), 32'h1000_0000 + 32'(i), 2'd2, 1,
                 32'h4000 + 32'(4 * i), 32'h1000_0000 + 32'(i), 4'b1111, 1);
        check("fill_full", {31'd0, full}, 32'd1);
        push(32'h4F00, 32'h5555_5555, 2'd2, 0, '0, '0, '0, 0);
        check("fill_full_after_drop", {31'd0, full}, 32'd1);
        awready = 1'b1;
        wait_empty("fill_drain");
        check("fill_drained", 32'(n_drained - base), 32'd4);

        // Reserved size still issues with no strobes
        push(32'h5001, 32'h0000_0077, 2'd3, 1, 32'h5000, 32'h0, 4'b0000, 0);
        wait_empty("rsvd_drain");

        // Split handshake
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
        push(32'h6008, 32'hCAFE_F00D, 2'd2, 1, 32'h6008, 32'hCAFE_F00D, 4'b1111, 1);
        tick();
        check("split_c1_awvalid", {31'd0, awvalid}, 32'd1);
        awready = 1'b1;
        tick();
        awready = 1'b0;
        check("split_c2_awvalid", {31'd0, awvalid}, 32'd0);
        check("split_c2_wvalid", {31'd0, wvalid}, 32'd1);
        check("split_c2_bready", {31'd0, bready}, 32'd0);
        tick();
        check("split_c3_wvalid", {31'd0, wvalid}, 32'd1);
        check("split_c3_bready", {31'd0, bready}, 32'd0);
        wready = 1'b1;
        tick();
        wready = 1'b0;
        check("split_resp_wvalid", {31'd0, wvalid}, 32'd0);
        check("split_resp_bready", {31'd0, bready}, 32'd1);
        bvalid = 1'b1;
        tick();
        bvalid = 1'b0;
        check("split_popped", {31'd0, empty}, 32'd1);

        // Error response
        awready = 1'b1; wready = 1'b1; bvalid = 1'b1; bresp = 3'd2;
        push(32'h7000, 32'h0000_0011, 2'd2, 1, 32'h7000, 32'h0000_0011, 4'b1111, 1);
        tick(); tick();
        check("err_before", {31'd0, bus_error}, 32'd0);
        tick();
        bresp = 3'd0;
        check("err_pulse", {31'd0, bus_error}, 32'd1);
        check("err_popped", {31'd0, empty}, 32'd1);
        tick();
        check("err_pulse_end", {31'd0, bus_error}, 32'd0);
        push(32'h7004, 32'h0000_0022, 2'd2, 1, 32'h7004, 32'h0000_0022, 4'b1111, 1);
        wait_empty("err_next_drain");
        check("err_next_clean", {31'd0, bus_error}, 32'd0);

        // Hazard probe, then reset while waiting for the response
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
        push(32'h3008, 32'h0000_0099, 2'd2, 1, 32'h3008, 32'h0000_0099, 4'b1111, 1);
        ld_addr = 32'h300B; #1;
        check("haz_same_word", {31'd0, ld_hazard}, 32'd1);
        ld_addr = 32'h300C; #1;
        check("haz_next_word", {31'd0, ld_hazard}, 32'd0);
        ld_addr = 32'h3008;
        awready = 1'b1; wready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (bready) break;
            tick();
        end
        check("rst_reach_resp", {31'd0, bready}, 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        sb.delete();
        check("rst_mid_empty", {31'd0, empty}, 32'd1);
        check("rst_mid_bready", {31'd0, bready}, 32'd0);
        check("rst_mid_hazard", {31'd0, ld_hazard}, 32'd0);

        check("sb_leftover", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/datafifo.md
DATAFIFO -- requirements
Module: datafifo

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, giving the number of store entries; DEPTH SHALL be a power of two and at least 2.
REQ-002 The block SHALL have these ports, one per line as name, direction, width, meaning:
- clk  in  1  sole clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- in_addr  in  32  store byte address from commit.
- in_val  in  32  store data, right-aligned.
- in_size  in  2  0 = byte, 1 = half, 2 = word, 3 = reserved.
- in_valid  in  1  push request.
- full  out  1  no free entry.
- empty  out  1  no pending entry.
- ld_addr  in  32  load address probed by execute.
- ld_hazard  out  1  a pending store overlaps the ld_addr word.
- awaddr  out  32  write address.
- awvalid  out  1  write address valid.
- awready  in  1  write address accepted.
- wdata  out  32  write data.
- wstrb  out  4  byte lane enables.
- wvalid  out  1  write data valid.
- wready  in  1  write data accepted.
- bresp  in  3  write response; nonzero means error.
- bvalid  in  1  write response valid.
- bready  out  1  response accepted.
- bus_error  out  1  one-cycle pulse when a store response is in error.

Function
REQ-003 full SHALL equal (count == DEPTH) and empty SHALL equal (count == 0); both SHALL decode combinationally from registered state only.
REQ-004 A push SHALL occur on an edge where in_valid=1 and full=0; the entry SHALL be written at the tail and the tail pointer SHALL wrap modulo DEPTH.
REQ-005 in_valid while full=1 SHALL be ignored, with no state change, even if a pop occurs on the same edge.
REQ-006 A simultaneous push and pop SHALL leave count unchanged and advance both pointers.
REQ-007 The head entry SHALL remain stored, and SHALL count toward count and ld_hazard, until its response is accepted.
REQ-008 The drain FSM SHALL have three states: IDLE, SEND and RESP.
- IDLE: go to SEND when empty=0.
- SEND: awvalid = !aw_done and wvalid = !w_done. aw_done and w_done are flags that set on their respective handshakes. Go to RESP on the edge where both flags are complete, including both handshakes in the same cycle.
- RESP: bready=1. On bvalid=1: pop the head, clear aw_done and w_done, and go to IDLE.
REQ-009 awvalid, wvalid and bready SHALL be 0 outside the states listed in REQ-008; awvalid and wvalid, once asserted, SHALL hold with stable payload until the handshake completes.
REQ-010 A store pushed into an empty FIFO at edge E SHALL enter SEND at edge E+1 and drive awvalid/wvalid in the following cycle; minimum push-to-pop time SHALL be 3 edges when ready and bvalid are already high.
REQ-011 awaddr SHALL be {head.addr[31:2], 2'b00}.
REQ-012 For head.size = 0, wdata SHALL be {4{val[7:0]}} and wstrb SHALL be 4'b0001 << addr[1:0].
REQ-013 For head.size = 1, wdata SHALL be {2{val[15:0]}} and wstrb SHALL be 4'b0011 << {addr[1], 1'b0}.
REQ-014 For head.size = 2, wdata SHALL be val and wstrb SHALL be 4'b1111.
REQ-015 For head.size = 3, wstrb SHALL be 4'b0000 and the transaction SHALL still be issued and popped.
REQ-016 bus_error SHALL be 1 for exactly the cycle after a response with bresp != 0 is accepted, and the entry SHALL still be popped.
REQ-017 ld_hazard SHALL be combinational: 1 if any entry counted in count has addr[31:2] == ld_addr[31:2], otherwise 0.

Reset
REQ-018 While reset=1 at an edge, the block SHALL clear count, both pointers, aw_done, w_done and bus_error, and SHALL enter IDLE.
REQ-019 After reset, the outputs SHALL be: full=0, empty=1, ld_hazard=0, awvalid=0, wvalid=0, bready=0, bus_error=0.
REQ-020 Reset mid-transaction SHALL abandon the outstanding transaction and discard every entry; entry storage contents SHALL be don't-care.

Verification
REQ-021 Word store: push addr 0x2004, val 0xDEADBEEF, size 2 with ready and bvalid held high -> awaddr 0x2004, wdata 0xDEADBEEF, wstrb 4'b1111; empty=1 three edges after the push.
REQ-022 Byte store: push addr 0x1003, val 0x000000AB, size 0 -> awaddr 0x1000, wdata 0xABABABAB, wstrb 4'b1000; half store at 0x1002 -> wstrb 4'b1100.
REQ-023 Fill: hold awready=0 and push 4 stores -> full=1 after the 4th push; the 5th push is dropped; a later drain emits the 4 stores in order with correct wrap.
REQ-024 Split handshake: awready pulsed in cycle 1 and wready pulsed in cycle 3 -> awvalid drops after cycle 1, wvalid holds until cycle 3, and the FSM enters RESP only after cycle 3.
REQ-025 Error response: bresp=2 with bvalid=1 -> bus_error=1 for exactly one cycle, the entry is popped, and the next store drains normally.
REQ-026 Hazard and reset: pending store at 0x3008 with ld_addr 0x300B -> ld_hazard=1; with ld_addr 0x300C -> ld_hazard=0; reset asserted in RESP -> empty=1, bready=0 on the next cycle.
